// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared sizing, index-width helper and FSM state type for the SNN readout
//
// Purpose: single source for the readout defaults (N classes, CW counter bits,
// TW tick-counter bits), the class-index width and the readout state enum.
package snn_pkg;

  localparam int SNN_N  = 96;
  localparam int SNN_CW = 8;
  localparam int SNN_TW = 16;

  // Index width for n entries; at least one bit so a single-class build still has a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SNN_IW = idx_width(SNN_N);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    HOLD  = 2'd2
  } snn_state_e;

endpackage

// File: rtl/snn_spike_counter_bank.sv
// rtl/snn_spike_counter_bank.sv - N saturating per-neuron spike counters with one read port
//
// Purpose: holds one CW-bit saturating counter per neuron.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clr_i         synchronous clear of every counter (wins over increment)
//   inc_en_i      add spikes_i[n] to counter n this cycle
//   spikes_i      one spike bit per neuron
//   rd_idx_i      counter selected for rd_cnt_o
//   rd_cnt_o      value of the selected counter (0 for out-of-range index)
//   sat_hit_o     some spiking neuron is already at full scale (increment would be lost)
module snn_spike_counter_bank
  import snn_pkg::*;
#(
  parameter int N  = SNN_N,
  parameter int CW = SNN_CW,
  localparam int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_en_i,
  input  logic [N-1:0]  spikes_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [CW-1:0] rd_cnt_o,
  output logic          sat_hit_o
);

  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [N-1:0]  at_max;

  always_comb begin
    for (int n = 0; n < N; n++) begin
      at_max[n] = (cnt_q[n] == {CW{1'b1}});
      cnt_d[n]  = cnt_q[n];
      if (clr_i) begin
        cnt_d[n] = '0;
      end else if (inc_en_i && spikes_i[n] && !at_max[n]) begin
        cnt_d[n] = cnt_q[n] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < N; n++) cnt_q[n] <= '0;
    end else begin
      for (int n = 0; n < N; n++) cnt_q[n] <= cnt_d[n];
    end
  end

  // Caller qualifies this with an accepted tick.
  assign sat_hit_o = |(spikes_i & at_max);

  assign rd_cnt_o = (int'(rd_idx_i) < N) ? cnt_q[rd_idx_i] : '0;

endmodule

// File: rtl/snn_readout.sv
// rtl/snn_readout.sv - windowed spike-count readout: accumulate, arg-max scan, hold result
//
// Purpose: counts spikes per output neuron over win_len ticks, then scans the
// counters one per cycle and presents the index/count of the highest counter.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   clr                       synchronous soft clear (overrides everything)
//   win_len                   ticks per window, captured on the first tick (0 means 1)
//   tick_valid, spikes_vec    one time-step of spikes; accepted while in_ready=1
//   in_ready                  high in ACCUM
//   result_valid/result_ready result handshake
//   result_class, result_count winner index and its count
//   sat_flag, drop_flag       sticky per-window status
module snn_readout
  import snn_pkg::*;
#(
  parameter int N  = SNN_N,
  parameter int CW = SNN_CW,
  parameter int TW = SNN_TW,
  localparam int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [TW-1:0] win_len,
  input  logic          tick_valid,
  input  logic [N-1:0]  spikes_vec,
  output logic          in_ready,
  output logic          result_valid,
  input  logic          result_ready,
  output logic [IW-1:0] result_class,
  output logic [CW-1:0] result_count,
  output logic          sat_flag,
  output logic          drop_flag
);

  snn_state_e    state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [TW-1:0] win_q, win_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] best_idx_q, best_idx_d;
  logic [CW-1:0] best_cnt_q, best_cnt_d;
  logic [IW-1:0] cls_q, cls_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          valid_q, valid_d;
  logic          sat_q, sat_d;
  logic          drop_q, drop_d;

  logic          accept;
  logic          handshake;
  logic          better;
  logic [TW-1:0] eff_len;
  logic [TW-1:0] tick_nxt;
  logic [CW-1:0] rd_cnt;
  logic          sat_hit;

  assign accept    = (state_q == ACCUM) && tick_valid;
  assign handshake = (state_q == HOLD) && result_ready;
  assign tick_nxt  = tick_cnt_q + 1'b1;
  // The first tick of a window uses the live win_len; later ticks use the captured copy.
  assign eff_len   = (tick_cnt_q != '0)    ? win_q :
                     (win_len == '0)       ? TW'(1) : win_len;
  // Strict compare keeps the lowest index on ties.
  assign better    = (rd_cnt > best_cnt_q);

  snn_spike_counter_bank #(
    .N  (N),
    .CW (CW)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr || handshake),
    .inc_en_i  (accept && !clr),
    .spikes_i  (spikes_vec),
    .rd_idx_i  (idx_q),
    .rd_cnt_o  (rd_cnt),
    .sat_hit_o (sat_hit)
  );

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    win_d      = win_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    cls_d      = cls_q;
    rcnt_d     = rcnt_q;
    valid_d    = valid_q;
    sat_d      = sat_q;
    drop_d     = drop_q;

    if (clr) begin
      state_d    = ACCUM;
      tick_cnt_d = '0;
      win_d      = '0;
      idx_d      = '0;
      best_idx_d = '0;
      best_cnt_d = '0;
      cls_d      = '0;
      rcnt_d     = '0;
      valid_d    = 1'b0;
      sat_d      = 1'b0;
      drop_d     = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            tick_cnt_d = tick_nxt;
            win_d      = eff_len;
            sat_d      = sat_q | sat_hit;
            if (tick_nxt == eff_len) begin
              state_d    = SCAN;
              idx_d      = '0;
              best_idx_d = '0;
              best_cnt_d = '0;
            end
          end
        end
        SCAN: begin
          drop_d = drop_q | tick_valid;
          if (better) begin
            best_idx_d = idx_q;
            best_cnt_d = rd_cnt;
          end
          if (idx_q == IW'(N - 1)) begin
            // Last counter is folded in directly so the result lands on this edge.
            cls_d   = better ? idx_q  : best_idx_q;
            rcnt_d  = better ? rd_cnt : best_cnt_q;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        HOLD: begin
          if (handshake) begin
            tick_cnt_d = '0;
            sat_d      = 1'b0;
            drop_d     = 1'b0;
            valid_d    = 1'b0;
            state_d    = ACCUM;
          end else begin
            drop_d = drop_q | tick_valid;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACCUM;
      tick_cnt_q <= '0;
      win_q      <= '0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      cls_q      <= '0;
      rcnt_q     <= '0;
      valid_q    <= 1'b0;
      sat_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      win_q      <= win_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      cls_q      <= cls_d;
      rcnt_q     <= rcnt_d;
      valid_q    <= valid_d;
      sat_q      <= sat_d;
      drop_q     <= drop_d;
    end
  end

  assign in_ready     = (state_q == ACCUM);
  assign result_valid = valid_q;
  assign result_class = cls_q;
  assign result_count = rcnt_q;
  assign sat_flag     = sat_q;
  assign drop_flag    = drop_q;

endmodule
